// File: rtl/rob_if.sv
// rob_if: issue, writeback, lookup, commit and flush signals of the reorder
// buffer. The slave modport is the ROB side; master is the core/bench side.
interface rob_if #(
  parameter int ROB_BIT = 3
);
  // issue
  logic               issue_valid;
  logic               issue_has_rd;
  logic [4:0]         issue_rd;
  logic               issue_is_branch;
  logic [ROB_BIT-1:0] rob_tail;
  logic               rob_full;
  logic               debug_rob_empty;
  // writeback buses (A = ALU, B = LSB)
  logic               wbA_valid;
  logic [ROB_BIT-1:0] wbA_entry;
  logic [31:0]        wbA_value;
  logic               wbA_mispredict;
  logic [31:0]        wbA_target;
  logic               wbB_valid;
  logic [ROB_BIT-1:0] wbB_entry;
  logic [31:0]        wbB_value;
  // dependency lookups
  logic [ROB_BIT-1:0] get_rob_entry1;
  logic [ROB_BIT-1:0] get_rob_entry2;
  logic               ready1;
  logic               ready2;
  logic [31:0]        value1;
  logic [31:0]        value2;
  // commit / flush
  logic               rob_commit;
  logic [4:0]         commit_reg_id;
  logic [31:0]        commit_reg_data;
  logic [ROB_BIT-1:0] commit_rob_entry;
  logic               rob_clear_up;
  logic [31:0]        clear_pc;

  modport slave (
    input  issue_valid, issue_has_rd, issue_rd, issue_is_branch,
    output rob_tail, rob_full, debug_rob_empty,
    input  wbA_valid, wbA_entry, wbA_value, wbA_mispredict, wbA_target,
    input  wbB_valid, wbB_entry, wbB_value,
    input  get_rob_entry1, get_rob_entry2,
    output ready1, ready2, value1, value2,
    output rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry,
    output rob_clear_up, clear_pc
  );

  modport master (
    output issue_valid, issue_has_rd, issue_rd, issue_is_branch,
    input  rob_tail, rob_full, debug_rob_empty,
    output wbA_valid, wbA_entry, wbA_value, wbA_mispredict, wbA_target,
    output wbB_valid, wbB_entry, wbB_value,
    output get_rob_entry1, get_rob_entry2,
    input  ready1, ready2, value1, value2,
    input  rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry,
    input  rob_clear_up, clear_pc
  );
endinterface

// File: rtl/rob_core.sv
// rob_core: reorder buffer with 2**ROB_BIT entries. Allocates in program
// order, collects results from two writeback buses, commits the head in
// order and flushes on a mispredicted branch at the head.
// Optional feature: define ROB_BYPASS_EN to forward same-cycle writebacks
// onto the dependency lookup ports.
module rob_core #(
  parameter int ROB_BIT = 3
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  rdy_in,
  rob_if.slave  rob
);
  localparam int DEPTH = 1 << ROB_BIT;
  localparam int CW    = ROB_BIT + 1;

  // entry storage
  logic        busy_q      [DEPTH];
  logic        busy_d      [DEPTH];
  logic        ready_q     [DEPTH];
  logic        ready_d     [DEPTH];
  logic        has_rd_q    [DEPTH];
  logic        has_rd_d    [DEPTH];
  logic [4:0]  rd_q        [DEPTH];
  logic [4:0]  rd_d        [DEPTH];
  logic [31:0] value_q     [DEPTH];
  logic [31:0] value_d     [DEPTH];
  logic        is_branch_q [DEPTH];
  logic        is_branch_d [DEPTH];
  logic        mispred_q   [DEPTH];
  logic        mispred_d   [DEPTH];
  logic [31:0] target_q    [DEPTH];
  logic [31:0] target_d    [DEPTH];

  // pointers
  logic [ROB_BIT-1:0] head_q, head_d;
  logic [ROB_BIT-1:0] tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  // registered outputs
  logic               commit_q, commit_d;
  logic [4:0]         commit_id_q, commit_id_d;
  logic [31:0]        commit_data_q, commit_data_d;
  logic [ROB_BIT-1:0] commit_entry_q, commit_entry_d;
  logic               clear_q, clear_d;
  logic [31:0]        clear_pc_q, clear_pc_d;

  logic full;
  logic empty;
  logic commit_fire;
  logic flush;
  logic issue_fire;
  logic wb_a_ok;
  logic wb_b_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // The cycle after a flush is dead: no commit, issue or writeback, since
  // anything arriving then belongs to the squashed path.
  assign commit_fire = !clear_q && busy_q[head_q] && ready_q[head_q];
  assign flush       = commit_fire && mispred_q[head_q] && is_branch_q[head_q];
  assign issue_fire  = rob.issue_valid && !clear_q && !flush &&
                       (!full || commit_fire);
  assign wb_a_ok     = rob.wbA_valid && !clear_q && !flush && busy_q[rob.wbA_entry];
  assign wb_b_ok     = rob.wbB_valid && !clear_q && !flush && busy_q[rob.wbB_entry];

  // Next-state: commit frees the head, writebacks land, then issue claims
  // the tail (which may be the entry just freed when the buffer was full).
  always_comb begin
    busy_d         = busy_q;
    ready_d        = ready_q;
    has_rd_d       = has_rd_q;
    rd_d           = rd_q;
    value_d        = value_q;
    is_branch_d    = is_branch_q;
    mispred_d      = mispred_q;
    target_d       = target_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_d       = 1'b0;
    commit_id_d    = commit_id_q;
    commit_data_d  = commit_data_q;
    commit_entry_d = commit_entry_q;
    clear_d        = 1'b0;
    clear_pc_d     = clear_pc_q;

    if (commit_fire) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
      commit_d        = 1'b1;
      commit_id_d     = has_rd_q[head_q] ? rd_q[head_q] : 5'd0;
      commit_data_d   = value_q[head_q];
      commit_entry_d  = head_q;
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_d[i]  = 1'b0;
        ready_d[i] = 1'b0;
      end
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      clear_d    = 1'b1;
      clear_pc_d = target_q[head_q];
    end else begin
      if (wb_b_ok) begin
        ready_d[rob.wbB_entry] = 1'b1;
        value_d[rob.wbB_entry] = rob.wbB_value;
      end
      // A is applied after B so it wins on a shared target
      if (wb_a_ok) begin
        ready_d[rob.wbA_entry]   = 1'b1;
        value_d[rob.wbA_entry]   = rob.wbA_value;
        mispred_d[rob.wbA_entry] = rob.wbA_mispredict;
        target_d[rob.wbA_entry]  = rob.wbA_target;
      end
      if (issue_fire) begin
        busy_d[tail_q]      = 1'b1;
        ready_d[tail_q]     = 1'b0;
        has_rd_d[tail_q]    = rob.issue_has_rd;
        rd_d[tail_q]        = rob.issue_rd;
        is_branch_d[tail_q] = rob.issue_is_branch;
        mispred_d[tail_q]   = 1'b0;
        target_d[tail_q]    = '0;
        value_d[tail_q]     = '0;
        tail_d              = tail_q + 1'b1;
      end
      count_d = count_q + CW'(issue_fire) - CW'(commit_fire);
    end
  end

  // State register; rdy_in low freezes everything including output pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]      <= 1'b0;
        ready_q[i]     <= 1'b0;
        has_rd_q[i]    <= 1'b0;
        rd_q[i]        <= '0;
        value_q[i]     <= '0;
        is_branch_q[i] <= 1'b0;
        mispred_q[i]   <= 1'b0;
        target_q[i]    <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_q       <= 1'b0;
      commit_id_q    <= '0;
      commit_data_q  <= '0;
      commit_entry_q <= '0;
      clear_q        <= 1'b0;
      clear_pc_q     <= '0;
    end else if (rdy_in) begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      has_rd_q       <= has_rd_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      is_branch_q    <= is_branch_d;
      mispred_q      <= mispred_d;
      target_q       <= target_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_q       <= commit_d;
      commit_id_q    <= commit_id_d;
      commit_data_q  <= commit_data_d;
      commit_entry_q <= commit_entry_d;
      clear_q        <= clear_d;
      clear_pc_q     <= clear_pc_d;
    end
  end

  // Dependency lookups for the decoder.
  always_comb begin
    rob.ready1 = busy_q[rob.get_rob_entry1] && ready_q[rob.get_rob_entry1];
    rob.value1 = value_q[rob.get_rob_entry1];
    rob.ready2 = busy_q[rob.get_rob_entry2] && ready_q[rob.get_rob_entry2];
    rob.value2 = value_q[rob.get_rob_entry2];
`ifdef ROB_BYPASS_EN
    if (rob.wbA_valid && busy_q[rob.get_rob_entry1] && rob.wbA_entry == rob.get_rob_entry1) begin
      rob.ready1 = 1'b1;
      rob.value1 = rob.wbA_value;
    end else if (rob.wbB_valid && busy_q[rob.get_rob_entry1] && rob.wbB_entry == rob.get_rob_entry1) begin
      rob.ready1 = 1'b1;
      rob.value1 = rob.wbB_value;
    end
    if (rob.wbA_valid && busy_q[rob.get_rob_entry2] && rob.wbA_entry == rob.get_rob_entry2) begin
      rob.ready2 = 1'b1;
      rob.value2 = rob.wbA_value;
    end else if (rob.wbB_valid && busy_q[rob.get_rob_entry2] && rob.wbB_entry == rob.get_rob_entry2) begin
      rob.ready2 = 1'b1;
      rob.value2 = rob.wbB_value;
    end
`else
`endif
  end

  assign rob.rob_tail         = tail_q;
  assign rob.rob_full         = full;
  assign rob.debug_rob_empty  = empty;
  assign rob.rob_commit       = commit_q;
  assign rob.commit_reg_id    = commit_id_q;
  assign rob.commit_reg_data  = commit_data_q;
  assign rob.commit_rob_entry = commit_entry_q;
  assign rob.rob_clear_up     = clear_q;
  assign rob.clear_pc         = clear_pc_q;
endmodule

// File: tb/tb_rob_core.sv
// tb_rob_core: directed stimulus for rob_core; expected commits and
// flushes are queued at issue time and consumed by a monitor process.
module tb_rob_core;
  localparam int RB = 3;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  rob_if #(.ROB_BIT(RB)) rif ();

  rob_core #(.ROB_BIT(RB)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rob    (rif)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [4:0]    id;
    logic [31:0]   data;
    logic [RB-1:0] entry;
  } commit_t;

  commit_t     exp_commit_q[$];
  logic [31:0] exp_clear_q[$];
  commit_t     mon_c;
  logic [31:0] mon_pc;
  int          checks = 0;
  int          errors = 0;
  logic        upd_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // registered outputs only change on an edge where rdy_in was high
  always @(posedge clk_in) upd_q <= rdy_in;

  // monitor: consume one expectation per fresh commit / flush pulse
  always @(negedge clk_in) begin
    if (!rst_in && upd_q) begin
      if (rif.rob_commit === 1'b1) begin
        if (exp_commit_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL commit_unexpected: got commit of entry %0d, expected none", rif.commit_rob_entry);
        end else begin
          mon_c = exp_commit_q.pop_front();
          check("commit_reg_id", 32'(rif.commit_reg_id), 32'(mon_c.id));
          check("commit_reg_data", rif.commit_reg_data, mon_c.data);
          check("commit_rob_entry", 32'(rif.commit_rob_entry), 32'(mon_c.entry));
        end
      end
      if (rif.rob_clear_up === 1'b1) begin
        if (exp_clear_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL clear_unexpected: got clear_pc 0x%0h, expected no flush", rif.clear_pc);
        end else begin
          mon_pc = exp_clear_q.pop_front();
          check("clear_pc", rif.clear_pc, mon_pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rif.issue_valid     = 1'b0;
    rif.issue_has_rd    = 1'b0;
    rif.issue_rd        = '0;
    rif.issue_is_branch = 1'b0;
    rif.wbA_valid       = 1'b0;
    rif.wbA_entry       = '0;
    rif.wbA_value       = '0;
    rif.wbA_mispredict  = 1'b0;
    rif.wbA_target      = '0;
    rif.wbB_valid       = 1'b0;
    rif.wbB_entry       = '0;
    rif.wbB_value       = '0;
    rif.get_rob_entry1  = '0;
    rif.get_rob_entry2  = '0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic has_rd, input logic br,
                       input logic [31:0] val, input logic [RB-1:0] ent, input bit push);
    commit_t c;
    if (push) begin
      c.id    = has_rd ? rd : 5'd0;
      c.data  = val;
      c.entry = ent;
      exp_commit_q.push_back(c);
    end
    rif.issue_valid     = 1'b1;
    rif.issue_has_rd    = has_rd;
    rif.issue_rd        = rd;
    rif.issue_is_branch = br;
    tick();
    rif.issue_valid = 1'b0;
  endtask

  task automatic wb_a(input logic [RB-1:0] ent, input logic [31:0] val);
    rif.wbA_valid      = 1'b1;
    rif.wbA_entry      = ent;
    rif.wbA_value      = val;
    rif.wbA_mispredict = 1'b0;
    tick();
    rif.wbA_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_commit_q.size() != 0 || exp_clear_q.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    check({name, "_pending"}, 32'(exp_commit_q.size() + exp_clear_q.size()), 32'd0);
    tick();
    check({name, "_empty"}, 32'(rif.debug_rob_empty), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle_inputs();

    // ---- reset state and a single instruction
    do_reset();
    check("rst_empty", 32'(rif.debug_rob_empty), 32'd1);
    check("rst_full", 32'(rif.rob_full), 32'd0);
    check("rst_tail", 32'(rif.rob_tail), 32'd0);
    check("rst_commit", 32'(rif.rob_commit), 32'd0);
    check("rst_clear", 32'(rif.rob_clear_up), 32'd0);
    check("rst_commit_id", 32'(rif.commit_reg_id), 32'd0);
    check("rst_commit_data", rif.commit_reg_data, 32'd0);
    check("rst_clear_pc", rif.clear_pc, 32'd0);
    issue(5'd5, 1'b1, 1'b0, 32'h1234, 3'd0, 1'b1);
    check("t1_tail", 32'(rif.rob_tail), 32'd1);
    check("t1_not_empty", 32'(rif.debug_rob_empty), 32'd0);
    wb_a(3'd0, 32'h1234);
    check("t1_no_early_commit", 32'(rif.rob_commit), 32'd0);
    tick();
    check("t1_commit", 32'(rif.rob_commit), 32'd1);
    tick();
    check("t1_pulse_end", 32'(rif.rob_commit), 32'd0);
    check("t1_empty", 32'(rif.debug_rob_empty), 32'd1);

    // ---- fill, overflow attempt, commit+issue while full
    do_reset();
    for (int i = 0; i < 8; i++)
      issue(5'(i + 1), 1'b1, 1'b0, 32'h100 + 32'(i), 3'(i), 1'b1);
    check("t2_full", 32'(rif.rob_full), 32'd1);
    check("t2_tail_wrap", 32'(rif.rob_tail), 32'd0);
    rif.issue_valid  = 1'b1;
    rif.issue_has_rd = 1'b1;
    rif.issue_rd     = 5'd31;
    tick();
    rif.issue_valid = 1'b0;
    check("t2_overflow_tail", 32'(rif.rob_tail), 32'd0);
    check("t2_overflow_full", 32'(rif.rob_full), 32'd1);
    wb_a(3'd0, 32'h100);
    issue(5'd9, 1'b1, 1'b0, 32'h200, 3'd0, 1'b1);
    check("t2_commit_issue", 32'(rif.rob_commit), 32'd1);
    check("t2_still_full", 32'(rif.rob_full), 32'd1);
    check("t2_tail_after", 32'(rif.rob_tail), 32'd1);
    for (int i = 1; i < 8; i++)
      wb_a(3'(i), 32'h100 + 32'(i));
    wb_a(3'd0, 32'h200);
    drain("t2");

    // ---- out-of-order writeback, in-order commit
    do_reset();
    issue(5'd10, 1'b1, 1'b0, 32'hA0, 3'd0, 1'b1);
    issue(5'd11, 1'b1, 1'b0, 32'hA1, 3'd1, 1'b1);
    issue(5'd12, 1'b1, 1'b0, 32'hA2, 3'd2, 1'b1);
    wb_a(3'd2, 32'hA2);
    check("t3_no_commit_e2", 32'(rif.rob_commit), 32'd0);
    wb_a(3'd0, 32'hA0);
    wb_a(3'd1, 32'hA1);
    check("t3_c0", 32'(rif.rob_commit), 32'd1);
    check("t3_c0_entry", 32'(rif.commit_rob_entry), 32'd0);
    tick();
    check("t3_c1", 32'(rif.rob_commit), 32'd1);
    check("t3_c1_entry", 32'(rif.commit_rob_entry), 32'd1);
    tick();
    check("t3_c2", 32'(rif.rob_commit), 32'd1);
    check("t3_c2_entry", 32'(rif.commit_rob_entry), 32'd2);
    drain("t3");

    // ---- mispredicted branch at entry 1 flushes entries 2..3
    do_reset();
    issue(5'd1, 1'b1, 1'b0, 32'h11, 3'd0, 1'b1);
    issue(5'd0, 1'b0, 1'b1, 32'h44, 3'd1, 1'b1);
    exp_clear_q.push_back(32'h80);
    issue(5'd2, 1'b1, 1'b0, 32'h0, 3'd2, 1'b0);
    issue(5'd3, 1'b1, 1'b0, 32'h0, 3'd3, 1'b0);
    rif.wbA_valid      = 1'b1;
    rif.wbA_entry      = 3'd1;
    rif.wbA_value      = 32'h44;
    rif.wbA_mispredict = 1'b1;
    rif.wbA_target     = 32'h80;
    rif.wbB_valid      = 1'b1;
    rif.wbB_entry      = 3'd0;
    rif.wbB_value      = 32'h11;
    tick();
    idle_inputs();
    tick();
    check("t4_c0_entry", 32'(rif.commit_rob_entry), 32'd0);
    check("t4_no_clear_yet", 32'(rif.rob_clear_up), 32'd0);
    rif.issue_valid  = 1'b1;
    rif.issue_has_rd = 1'b1;
    rif.issue_rd     = 5'd20;
    tick();
    check("t4_c1_entry", 32'(rif.commit_rob_entry), 32'd1);
    check("t4_clear", 32'(rif.rob_clear_up), 32'd1);
    check("t4_clear_pc", rif.clear_pc, 32'h80);
    check("t4_flush_tail", 32'(rif.rob_tail), 32'd0);
    check("t4_flush_empty", 32'(rif.debug_rob_empty), 32'd1);
    rif.wbA_valid = 1'b1;
    rif.wbA_entry = 3'd2;
    rif.wbA_value = 32'h99;
    tick();
    idle_inputs();
    check("t4_clear_end", 32'(rif.rob_clear_up), 32'd0);
    check("t4_no_commit", 32'(rif.rob_commit), 32'd0);
    check("t4_tail_after", 32'(rif.rob_tail), 32'd0);
    check("t4_empty_after", 32'(rif.debug_rob_empty), 32'd1);
    rif.get_rob_entry1 = 3'd2;
    #1;
    check("t4_stale_lookup", 32'(rif.ready1), 32'd0);
    drain("t4");

    // ---- lookups, same-cycle writeback, A over B
    do_reset();
    issue(5'd4, 1'b1, 1'b0, 32'h55, 3'd0, 1'b1);
    issue(5'd5, 1'b1, 1'b0, 32'h77, 3'd1, 1'b1);
    issue(5'd6, 1'b1, 1'b0, 32'h66, 3'd2, 1'b1);
    issue(5'd7, 1'b1, 1'b0, 32'hBEEF, 3'd3, 1'b1);
    rif.get_rob_entry1 = 3'd3;
    rif.get_rob_entry2 = 3'd0;
    rif.wbB_valid = 1'b1;
    rif.wbB_entry = 3'd3;
    rif.wbB_value = 32'hBEEF;
    rif.wbA_valid = 1'b1;
    rif.wbA_entry = 3'd0;
    rif.wbA_value = 32'h55;
    #1;
`ifdef ROB_BYPASS_EN
    check("t5_byp_ready1", 32'(rif.ready1), 32'd1);
    check("t5_byp_value1", rif.value1, 32'hBEEF);
    check("t5_byp_ready2", 32'(rif.ready2), 32'd1);
    check("t5_byp_value2", rif.value2, 32'h55);
`else
    check("t5_nobyp_ready1", 32'(rif.ready1), 32'd0);
    check("t5_nobyp_ready2", 32'(rif.ready2), 32'd0);
`endif
    tick();
    rif.wbA_valid = 1'b0;
    rif.wbB_valid = 1'b0;
    check("t5_ready1", 32'(rif.ready1), 32'd1);
    check("t5_value1", rif.value1, 32'hBEEF);
    check("t5_ready2", 32'(rif.ready2), 32'd1);
    check("t5_value2", rif.value2, 32'h55);
    rif.get_rob_entry1 = 3'd1;
    rif.wbA_valid = 1'b1;
    rif.wbA_entry = 3'd1;
    rif.wbA_value = 32'h77;
    rif.wbB_valid = 1'b1;
    rif.wbB_entry = 3'd1;
    rif.wbB_value = 32'h88;
    #1;
`ifdef ROB_BYPASS_EN
    check("t5_byp_a_wins", rif.value1, 32'h77);
`else
    check("t5_nobyp_e1", 32'(rif.ready1), 32'd0);
`endif
    tick();
    rif.wbA_valid = 1'b0;
    rif.wbB_valid = 1'b0;
    check("t5_a_wins_ready", 32'(rif.ready1), 32'd1);
    check("t5_a_wins_value", rif.value1, 32'h77);
    wb_a(3'd2, 32'h66);
    drain("t5");

    // ---- rdy_in low freezes commit and pointers
    do_reset();
    issue(5'd7, 1'b1, 1'b0, 32'h7777, 3'd0, 1'b1);
    rif.wbA_valid = 1'b1;
    rif.wbA_entry = 3'd0;
    rif.wbA_value = 32'h7777;
    tick();
    rif.wbA_valid = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_hold_commit", 32'(rif.rob_commit), 32'd0);
      check("t6_hold_tail", 32'(rif.rob_tail), 32'd1);
      check("t6_hold_empty", 32'(rif.debug_rob_empty), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    check("t6_commit", 32'(rif.rob_commit), 32'd1);
    check("t6_commit_entry", 32'(rif.commit_rob_entry), 32'd0);
    rdy_in = 1'b0;
    tick();
    check("t6_pulse_held", 32'(rif.rob_commit), 32'd1);
    rdy_in = 1'b1;
    tick();
    check("t6_pulse_end", 32'(rif.rob_commit), 32'd0);
    check("t6_empty", 32'(rif.debug_rob_empty), 32'd1);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
